control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multi-cycle FSM control unit of the simple RISC processor. Steps each instruction through IF/ID/EX/MEM/WB.
//  Emits one-hot stage enables plus datapath mux selects and strobes, decoded from the 6-bit opcode,
//  ALU flags (zero/negative) and stack flags (full/empty). Sits between instruction memory and the datapath.
// PARAMETERS
//  none; opcodes come from the shared constants package.
// PORTS
//  clock            in   1  rising-edge clock; one clock; reset is asynchronous and active-high
//  reset            in   1  asynchronous, active-high; FSM -> IF
//  sigPCSrc         out  3  next PC: 0 PC+1, 1 branch target, 2 jump target, 3 stack top (RET), 4-7 reserved
//  sigDstReg        out  1  RF write addr: 0 Rd, 1 Rs
//  sigRB            out  1  RF port-B read addr: 0 Rt, 1 Rd (store/push data)
//  sigENW           out  1  RF write enable
//  sigALUSrc        out  1  ALU B: 0 RB, 1 extended immediate
//  sigALUOp         out  2  00 AND, 01 ADD, 10 SUB
//  sigExt           out  1  0 zero-extend, 1 sign-extend
//  sigNewSP         out  2  00 hold, 01 SP+1, 10 SP-1
//  sigStackMem      out  1  mem addr: 0 ALU result, 1 SP
//  sigAddData       out  1  mem write data: 0 RB, 1 PC+1
//  sigMemR/sigMemW  out  1  data-memory read / write strobes
//  sigWB            out  1  RF write data: 0 ALU, 1 memory
//  sigWriteVal      out  1  1: also write Rs <- Rs+1 (LWPOI post-increment)
//  enIF enID enE enMem enWRB  out 1 each  one-hot stage enables
//  zeroFlag negativeFlag fullFlag emptyFlag  in 1 each  ALU and stack status
//  instructionCode  in   6  opcode
// BEHAVIOUR
//  Opcodes: AND0 ADD1 SUB2 ANDI3 ADDI4 LW5 LWPOI6 SW7 BGT8 BLT9 BEQ10 BNE11 JMP12 CALL13 RET14 PUSH15 POP16.
//  States IF,ID,EX,MEM,WB; one state per clock; enables are a Moore decode of the state.
//  Opcode is latched on the IF->ID edge and held to the end of the instruction.
//  Sequences, in cycles:
//   ALU ops: IF ID EX WB (4). LW/LWPOI/POP: IF ID EX MEM WB (5). SW/PUSH: IF ID EX MEM (4).
//   BGT..BNE: IF ID EX (3). JMP: IF ID (2). CALL/RET: IF ID MEM (3). Opcodes 17-63: NOP, IF ID (2).
//  ALU: AND/ANDI 00, ADD/ADDI/LW/LWPOI/SW 01, branches 10 (SUB compare). ALUSrc=1 for I-type mem ops; Ext=0 only ANDI.
//  Branch taken, evaluated combinationally in EX:
//   BGT = N; BLT = !N & !Z; BEQ = Z; BNE = !Z.
//   Taken -> PCSrc=1, else 0.
//  PCSrc: JMP/CALL 2; RET 3 when !emptyFlag, else 0.
//  The datapath loads PC on the edge leaving the final state.
//  Strobe gating:
//   MemR/MemW are high only in MEM; ENW only in WB; NewSP is non-hold only in MEM.
//   All are 0 in other states.
//  Stack operations:
//   PUSH: StackMem=1, RB=1, MemW, NewSP=01.
//   CALL: StackMem=1, AddData=1, MemW, NewSP=01.
//   POP: StackMem=1, MemR, NewSP=10, WB=1, ENW.
//   RET: StackMem=1, MemR, NewSP=10.
//  Full stack: PUSH/CALL suppress MemW and hold SP; CALL still jumps.
//  Empty stack: POP/RET suppress MemR, ENW and SP change; RET falls through to PC+1.
//  The cycle count is unchanged in the full/empty cases.
//  LWPOI WB: ENW=1, WB=1, DstReg=0, WriteVal=1. SW MEM: RB=1, MemW.
//  Reset (async, any state): state=IF, enIF=1, other enables 0, all strobes 0, NewSP=00, PCSrc=0.
// STRUCTURE
//  Shared package: opcode constants, state encoding, PCSrc/ALUOp/NewSP encodings.
//  One sub-module, stage_sequencer: state register, next-state logic, enable decode.
//  Top level: opcode latch and signal decode.
//  Benches drive clock from the bench clock generator: period 10, first rising edge at 5.
// TESTING
//  ADD, flags 0 -> enables IF,ID,E,WRB over 4 clocks; ENW=1 only in WB; ALUOp=01.
//  LWPOI -> 5 clocks; MemR in MEM; WB has ENW=1, WB=1, WriteVal=1.
//  BGT with N=1 -> 3 clocks, PCSrc=1; N=0 -> PCSrc=0. BEQ Z=1 taken, BNE Z=1 not taken.
//  JMP -> IF,ID then IF; PCSrc=2. CALL -> MemW, AddData=1, NewSP=01 in MEM.
//  PUSH full=0 -> MemW, NewSP=01 in MEM. PUSH full=1 -> 4 clocks, MemW=0, NewSP=00.
//  POP empty=1 -> 5 clocks, MemR=ENW=0. Reset asserted in EX -> IF next, strobes 0 at once.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, stage encoding,
// and the PC-source / ALU-op / stack-pointer select encodings.
package control_unit_pkg;

  localparam logic [5:0] opAnd   = 6'd0;
  localparam logic [5:0] opAdd   = 6'd1;
  localparam logic [5:0] opSub   = 6'd2;
  localparam logic [5:0] opAndi  = 6'd3;
  localparam logic [5:0] opAddi  = 6'd4;
  localparam logic [5:0] opLw    = 6'd5;
  localparam logic [5:0] opLwpoi = 6'd6;
  localparam logic [5:0] opSw    = 6'd7;
  localparam logic [5:0] opBgt   = 6'd8;
  localparam logic [5:0] opBlt   = 6'd9;
  localparam logic [5:0] opBeq   = 6'd10;
  localparam logic [5:0] opBne   = 6'd11;
  localparam logic [5:0] opJmp   = 6'd12;
  localparam logic [5:0] opCall  = 6'd13;
  localparam logic [5:0] opRet   = 6'd14;
  localparam logic [5:0] opPush  = 6'd15;
  localparam logic [5:0] opPop   = 6'd16;

  localparam logic [2:0] pcInc    = 3'd0;
  localparam logic [2:0] pcBranch = 3'd1;
  localparam logic [2:0] pcJump   = 3'd2;
  localparam logic [2:0] pcStack  = 3'd3;

  localparam logic [1:0] aluAnd = 2'b00;
  localparam logic [1:0] aluAdd = 2'b01;
  localparam logic [1:0] aluSub = 2'b10;

  localparam logic [1:0] spHold = 2'b00;
  localparam logic [1:0] spInc  = 2'b01;
  localparam logic [1:0] spDec  = 2'b10;

  typedef enum logic [2:0] {
    sIF  = 3'd0,
    sID  = 3'd1,
    sEX  = 3'd2,
    sMEM = 3'd3,
    sWB  = 3'd4
  } stateT;

  function automatic logic isAluOp(input logic [5:0] op);
    return op <= opAddi;
  endfunction

  function automatic logic isBranch(input logic [5:0] op);
    return (op >= opBgt) && (op <= opBne);
  endfunction

  // One-hot {IF, ID, EX, MEM, WB}
  function automatic logic [4:0] stageEnables(input stateT st);
    case (st)
      sIF:     return 5'b10000;
      sID:     return 5'b01000;
      sEX:     return 5'b00100;
      sMEM:    return 5'b00010;
      sWB:     return 5'b00001;
      default: return 5'b10000;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the control unit (master) and the datapath (slave).
interface control_unit_if;
  logic [2:0] sigPCSrc;
  logic       sigDstReg;
  logic       sigRB;
  logic       sigENW;
  logic       sigALUSrc;
  logic [1:0] sigALUOp;
  logic       sigExt;
  logic [1:0] sigNewSP;
  logic       sigStackMem;
  logic       sigAddData;
  logic       sigMemR;
  logic       sigMemW;
  logic       sigWB;
  logic       sigWriteVal;
  logic       enIF, enID, enE, enMem, enWRB;
  logic       zeroFlag, negativeFlag, fullFlag, emptyFlag;
  logic [5:0] instructionCode;

  modport master (
    output sigPCSrc, sigDstReg, sigRB, sigENW, sigALUSrc, sigALUOp, sigExt,
           sigNewSP, sigStackMem, sigAddData, sigMemR, sigMemW, sigWB, sigWriteVal,
           enIF, enID, enE, enMem, enWRB,
    input  zeroFlag, negativeFlag, fullFlag, emptyFlag, instructionCode
  );

  modport slave (
    input  sigPCSrc, sigDstReg, sigRB, sigENW, sigALUSrc, sigALUOp, sigExt,
           sigNewSP, sigStackMem, sigAddData, sigMemR, sigMemW, sigWB, sigWriteVal,
           enIF, enID, enE, enMem, enWRB,
    output zeroFlag, negativeFlag, fullFlag, emptyFlag, instructionCode
  );
endinterface

// File: rtl/control_unit_stage_sequencer.sv
// Stage sequencer: state register, per-opcode next-stage logic, registered one-hot enables.
//  state | meaning
//  sIF   | instruction fetch; opcode latched on exit
//  sID   | decode; JMP/NOP end here
//  sEX   | execute; branches resolve and end here
//  sMEM  | data memory / stack access; SW, PUSH, CALL, RET end here
//  sWB   | register-file write back
module stage_sequencer
  import control_unit_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  output stateT      state,
  output logic       enIF,
  output logic       enID,
  output logic       enE,
  output logic       enMem,
  output logic       enWRB
);

  stateT      nextState;
  logic [4:0] enables;

  always_comb begin
    nextState = sIF;
    case (state)
      sIF: nextState = sID;
      sID: begin
        if (opcode == opCall || opcode == opRet)       nextState = sMEM;
        else if (opcode <= opPop && opcode != opJmp)   nextState = sEX;
        else                                           nextState = sIF;
      end
      sEX: begin
        if (isBranch(opcode))     nextState = sIF;
        else if (isAluOp(opcode)) nextState = sWB;
        else                      nextState = sMEM;
      end
      sMEM: begin
        if (opcode == opLw || opcode == opLwpoi || opcode == opPop) nextState = sWB;
        else                                                        nextState = sIF;
      end
      default: nextState = sIF;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= sIF;
      enables <= 5'b10000;
    end else begin
      state   <= nextState;
      enables <= stageEnables(nextState);
    end
  end

  assign {enIF, enID, enE, enMem, enWRB} = enables;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: latches the opcode at fetch and decodes datapath
// selects and stage-gated strobes from the latched opcode, stage and flags.
module control_unit
  import control_unit_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  control_unit_if.master  bus
);

  stateT      state;
  logic [5:0] opcode;
  logic       taken;

  stage_sequencer uSequencer (
    .clock  (clock),
    .reset  (reset),
    .opcode (opcode),
    .state  (state),
    .enIF   (bus.enIF),
    .enID   (bus.enID),
    .enE    (bus.enE),
    .enMem  (bus.enMem),
    .enWRB  (bus.enWRB)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             opcode <= opAnd;
    else if (state == sIF) opcode <= bus.instructionCode;
  end

  always_comb begin
    case (opcode)
      opBgt:   taken = bus.negativeFlag;
      opBlt:   taken = !bus.negativeFlag && !bus.zeroFlag;
      opBeq:   taken = bus.zeroFlag;
      opBne:   taken = !bus.zeroFlag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    bus.sigPCSrc    = pcInc;
    bus.sigDstReg   = 1'b0;
    bus.sigRB       = 1'b0;
    bus.sigENW      = 1'b0;
    bus.sigALUSrc   = 1'b0;
    bus.sigALUOp    = aluAnd;
    bus.sigExt      = 1'b0;
    bus.sigNewSP    = spHold;
    bus.sigStackMem = 1'b0;
    bus.sigAddData  = 1'b0;
    bus.sigMemR     = 1'b0;
    bus.sigMemW     = 1'b0;
    bus.sigWB       = 1'b0;
    bus.sigWriteVal = 1'b0;

    // In IF the latched opcode belongs to the previous instruction, so selects stay quiet.
    if (state != sIF) begin
      bus.sigDstReg   = (opcode == opAndi) || (opcode == opAddi) || (opcode == opLw);
      bus.sigRB       = (opcode == opSw) || (opcode == opPush);
      bus.sigALUSrc   = (opcode >= opAndi) && (opcode <= opSw);
      bus.sigExt      = (opcode != opAndi);
      bus.sigStackMem = (opcode >= opCall) && (opcode <= opPop);
      bus.sigAddData  = (opcode == opCall);
      bus.sigWB       = (opcode == opLw) || (opcode == opLwpoi) || (opcode == opPop);
      case (opcode)
        opAnd, opAndi:                     bus.sigALUOp = aluAnd;
        opAdd, opAddi, opLw, opLwpoi, opSw: bus.sigALUOp = aluAdd;
        opSub, opBgt, opBlt, opBeq, opBne: bus.sigALUOp = aluSub;
        default:                           bus.sigALUOp = aluAnd;
      endcase
    end

    case (state)
      sID: if (opcode == opJmp) bus.sigPCSrc = pcJump;
      sEX: if (isBranch(opcode) && taken) bus.sigPCSrc = pcBranch;
      sMEM: begin
        case (opcode)
          opLw, opLwpoi: bus.sigMemR = 1'b1;
          opSw:          bus.sigMemW = 1'b1;
          opPush: if (!bus.fullFlag) begin
            bus.sigMemW  = 1'b1;
            bus.sigNewSP = spInc;
          end
          opCall: begin
            bus.sigPCSrc = pcJump;
            if (!bus.fullFlag) begin
              bus.sigMemW  = 1'b1;
              bus.sigNewSP = spInc;
            end
          end
          opPop: if (!bus.emptyFlag) begin
            bus.sigMemR  = 1'b1;
            bus.sigNewSP = spDec;
          end
          // An empty stack turns RET into a plain fall-through.
          opRet: if (!bus.emptyFlag) begin
            bus.sigMemR  = 1'b1;
            bus.sigNewSP = spDec;
            bus.sigPCSrc = pcStack;
          end
          default: ;
        endcase
      end
      sWB: begin
        bus.sigENW = isAluOp(opcode) || (opcode == opLw) || (opcode == opLwpoi) ||
                     ((opcode == opPop) && !bus.emptyFlag);
        bus.sigWriteVal = (opcode == opLwpoi);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instructions stage by stage and checks
// enables, strobes and selects against hand-computed values.
module tb_control_unit;

  logic clock;
  logic reset;
  int   nChecks;
  int   nPass;
  int   nFail;

  control_unit_if cuIf ();

  control_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (cuIf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [4:0] enVec();
    return {cuIf.enIF, cuIf.enID, cuIf.enE, cuIf.enMem, cuIf.enWRB};
  endfunction

  // {MemR, MemW, ENW, NewSP[1:0], PCSrc[2:0]}
  function automatic logic [7:0] strbVec();
    return {cuIf.sigMemR, cuIf.sigMemW, cuIf.sigENW, cuIf.sigNewSP, cuIf.sigPCSrc};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic stage(input string tag, input logic [4:0] expEn, input logic [7:0] expStrb);
    check({tag, "_en"}, {3'b000, enVec()}, {3'b000, expEn});
    check({tag, "_strb"}, strbVec(), expStrb);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic issue(input logic [5:0] op, input logic z, input logic n,
                       input logic f, input logic e);
    cuIf.instructionCode = op;
    cuIf.zeroFlag        = z;
    cuIf.negativeFlag    = n;
    cuIf.fullFlag        = f;
    cuIf.emptyFlag       = e;
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    nFail   = 0;
    reset   = 1'b1;
    issue(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    stage("reset", 5'b10000, 8'h00);
    reset = 1'b0;

    // ADD: IF ID EX WB; opcode changed after fetch must not matter
    issue(6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    stage("add_if", 5'b10000, 8'h00);
    cyc(); stage("add_id", 5'b01000, 8'h00);
    cuIf.instructionCode = 6'd5;
    cyc(); stage("add_ex", 5'b00100, 8'h00);
    check("add_aluop", {6'b0, cuIf.sigALUOp}, 8'd1);
    cyc(); stage("add_wb", 5'b00001, 8'b0010_0000);
    cyc(); stage("add_done", 5'b10000, 8'h00);

    // LWPOI: 5 stages
    issue(6'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); stage("lwpoi_id", 5'b01000, 8'h00);
    cyc(); stage("lwpoi_ex", 5'b00100, 8'h00);
    check("lwpoi_alusrc", {7'b0, cuIf.sigALUSrc}, 8'd1);
    cyc(); stage("lwpoi_mem", 5'b00010, 8'b1000_0000);
    cyc(); stage("lwpoi_wb", 5'b00001, 8'b0010_0000);
    check("lwpoi_wbsel", {5'b0, cuIf.sigWB, cuIf.sigWriteVal, cuIf.sigDstReg}, 8'b0000_0110);
    cyc(); stage("lwpoi_done", 5'b10000, 8'h00);

    // BGT taken (N=1)
    issue(6'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); stage("bgt1_id", 5'b01000, 8'h00);
    cyc(); stage("bgt1_ex", 5'b00100, 8'b0000_0001);
    check("bgt1_aluop", {6'b0, cuIf.sigALUOp}, 8'd2);
    cyc(); stage("bgt1_done", 5'b10000, 8'h00);

    // BGT not taken (N=0)
    issue(6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); stage("bgt0_ex", 5'b00100, 8'h00);
    cyc(); stage("bgt0_done", 5'b10000, 8'h00);

    // BLT taken (N=0, Z=0)
    issue(6'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); stage("blt_ex", 5'b00100, 8'b0000_0001);
    cyc();

    // BEQ Z=1 taken
    issue(6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); stage("beq_ex", 5'b00100, 8'b0000_0001);
    cyc();

    // BNE Z=1 not taken
    issue(6'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); stage("bne_ex", 5'b00100, 8'h00);
    cyc(); stage("bne_done", 5'b10000, 8'h00);

    // JMP: IF ID then IF
    issue(6'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); stage("jmp_id", 5'b01000, 8'b0000_0010);
    cyc(); stage("jmp_done", 5'b10000, 8'h00);

    // CALL, stack not full
    issue(6'd13, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); stage("call_id", 5'b01000, 8'h00);
    cyc(); stage("call_mem", 5'b00010, 8'b0100_1010);
    check("call_sel", {6'b0, cuIf.sigAddData, cuIf.sigStackMem}, 8'b0000_0011);
    cyc(); stage("call_done", 5'b10000, 8'h00);

    // PUSH, stack not full
    issue(6'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); stage("push_ex", 5'b00100, 8'h00);
    cyc(); stage("push_mem", 5'b00010, 8'b0100_1000);
    check("push_rb", {7'b0, cuIf.sigRB}, 8'd1);
    cyc(); stage("push_done", 5'b10000, 8'h00);

    // PUSH, stack full: same length, no write, SP held
    issue(6'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(); cyc(); cyc(); stage("pushf_mem", 5'b00010, 8'h00);
    cyc(); stage("pushf_done", 5'b10000, 8'h00);

    // POP, stack empty: 5 stages, nothing strobed
    issue(6'd16, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); cyc(); cyc(); stage("pope_mem", 5'b00010, 8'h00);
    cyc(); stage("pope_wb", 5'b00001, 8'h00);
    cyc(); stage("pope_done", 5'b10000, 8'h00);

    // POP, stack non-empty
    issue(6'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); cyc(); stage("pop_mem", 5'b00010, 8'b1001_0000);
    cyc(); stage("pop_wb", 5'b00001, 8'b0010_0000);
    cyc();

    // RET, stack non-empty
    issue(6'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); stage("ret_mem", 5'b00010, 8'b1001_0011);
    cyc(); stage("ret_done", 5'b10000, 8'h00);

    // RET, stack empty: falls through
    issue(6'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); cyc(); stage("rete_mem", 5'b00010, 8'h00);
    cyc();

    // Undefined opcode behaves as NOP
    issue(6'd40, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); stage("nop_id", 5'b01000, 8'h00);
    cyc(); stage("nop_done", 5'b10000, 8'h00);

    // Asynchronous reset while a taken branch is in EX
    issue(6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); stage("rst_pre", 5'b00100, 8'b0000_0001);
    #1 reset = 1'b1;
    #1 stage("rst_async", 5'b10000, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    stage("rst_if", 5'b10000, 8'h00);
    cyc(); stage("rst_id", 5'b01000, 8'h00);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
